// File: rtl/drink_machine.sv
// drink_machine: coin-operated drink vending controller.
// Accumulates nickel/dime/quarter credit, vends the highest-priority held
// selection once credit reaches PRICE, then clears the credit.
// Optional build macro DRINK_CHANGE_EN adds a registered 'change' output
// carrying the overpayment (in nickel units) during the vend cycle.
module drink_machine #(
  parameter int PRICE      = 5,
  parameter int MAX_CREDIT = 10
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] coin,
  input  logic       coke,
  input  logic       pepsi,
  input  logic       soft_drink,
  output logic       vendcoke,
  output logic       vendpepsi,
  output logic       vendsoft_drink
`ifdef DRINK_CHANGE_EN
  ,
  output logic [3:0] change
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2
  } state_e;

  localparam logic [3:0] PriceL = 4'(PRICE);
  localparam logic [4:0] MaxW   = 5'(MAX_CREDIT);

  state_e      state_q, state_d;
  logic [3:0]  credit_q, credit_d;
  logic [1:0]  coinPrev_q;
  logic [2:0]  vend_q, vend_d;
  logic        coinAccept;
  logic        vendNow;
  logic        anySel;
  logic [2:0]  coinValue;
  logic [3:0]  creditBase;
  logic [4:0]  creditSum;
`ifdef DRINK_CHANGE_EN
  logic [3:0]  change_q, change_d;
`endif

  // Decode the coin edge, decide whether to vend and compute the next credit.
  always_comb begin
    coinAccept = (coin != 2'd0) && (coinPrev_q == 2'd0);
    anySel     = coke | pepsi | soft_drink;

    coinValue = 3'd0;
    case (coin)
      2'd1:    coinValue = 3'd1;
      2'd2:    coinValue = 3'd2;
      2'd3:    coinValue = 3'd5;
      default: coinValue = 3'd0;
    endcase

    // The VEND state blocks a second vend on the very next edge.
    vendNow = (state_q != VEND) && (credit_q >= PriceL) && anySel;

    // When vending, the old credit is consumed and only a same-edge coin survives.
    creditBase = vendNow ? 4'd0 : credit_q;
    creditSum  = {1'b0, creditBase} + {2'b00, coinValue};

    credit_d = creditBase;
    if (coinAccept) begin
      credit_d = (creditSum > MaxW) ? MaxW[3:0] : creditSum[3:0];
    end

    state_d = IDLE;
    if (vendNow) begin
      state_d = VEND;
    end else if (credit_d != 4'd0) begin
      state_d = COLLECT;
    end

    vend_d = 3'b000;
    if (vendNow) begin
      if (coke) begin
        vend_d = 3'b100;
      end else if (pepsi) begin
        vend_d = 3'b010;
      end else begin
        vend_d = 3'b001;
      end
    end

`ifdef DRINK_CHANGE_EN
    change_d = vendNow ? (credit_q - PriceL) : 4'd0;
`endif
  end

  // State, credit, coin history and registered vend pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      credit_q   <= 4'd0;
      coinPrev_q <= 2'd0;
      vend_q     <= 3'b000;
`ifdef DRINK_CHANGE_EN
      change_q   <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      coinPrev_q <= coin;
      vend_q     <= vend_d;
`ifdef DRINK_CHANGE_EN
      change_q   <= change_d;
`endif
    end
  end

  assign vendcoke       = vend_q[2];
  assign vendpepsi      = vend_q[1];
  assign vendsoft_drink = vend_q[0];
`ifdef DRINK_CHANGE_EN
  assign change         = change_q;
`endif

endmodule

// File: tb/tb_drink_machine.sv
// tb_drink_machine: directed scoreboard bench for drink_machine.
// Expected vend/change values are queued as each cycle's stimulus is driven
// and popped when the DUT output for that edge is sampled.
module tb_drink_machine;

  logic       clock = 1'b0;
  logic       resetn;
  logic [1:0] coin;
  logic       coke;
  logic       pepsi;
  logic       soft_drink;
  logic       vendcoke;
  logic       vendpepsi;
  logic       vendsoft_drink;
`ifdef DRINK_CHANGE_EN
  logic [3:0] change;
`endif

  typedef struct packed {
    logic [2:0] vend;
    logic [3:0] chg;
  } exp_t;

  exp_t       expQ[$];
  int         total = 0;
  int         bad   = 0;
  logic [2:0] prevVend = 3'b000;

  drink_machine #(.PRICE(5), .MAX_CREDIT(10)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .coin           (coin),
    .coke           (coke),
    .pepsi          (pepsi),
    .soft_drink     (soft_drink),
    .vendcoke       (vendcoke),
    .vendpepsi      (vendpepsi),
    .vendsoft_drink (vendsoft_drink)
`ifdef DRINK_CHANGE_EN
    ,
    .change         (change)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag);
    exp_t       e;
    logic [2:0] obs;
    obs = {vendcoke, vendpepsi, vendsoft_drink};
    total++;
    assert (expQ.size() > 0) else begin
      bad++;
      $error("FAIL %s scoreboard: observed empty queue, expected an entry", tag);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      assert (obs === e.vend) else begin
        bad++;
        $error("FAIL %s vend: observed %b expected %b", tag, obs, e.vend);
      end
`ifdef DRINK_CHANGE_EN
      total++;
      assert (change === e.chg) else begin
        bad++;
        $error("FAIL %s change: observed %0d expected %0d", tag, change, e.chg);
      end
`endif
    end
    total++;
    assert ($onehot0(obs) && !((|obs) && (|prevVend))) else begin
      bad++;
      $error("FAIL %s exclusive: observed %b after %b expected onehot0 non-consecutive", tag, obs, prevVend);
    end
    prevVend = obs;
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic [2:0] sel,
                               input logic [2:0] expVend, input logic [3:0] expChg,
                               input string tag);
    exp_t e;
    @(negedge clock);
    coin = c;
    {coke, pepsi, soft_drink} = sel;
    e.vend = expVend;
    e.chg  = expChg;
    expQ.push_back(e);
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkCredit(input logic [3:0] expCredit, input string tag);
    total++;
    assert (dut.credit_q === expCredit) else begin
      bad++;
      $error("FAIL %s credit: observed %0d expected %0d", tag, dut.credit_q, expCredit);
    end
  endtask

  task automatic checkVendLow(input string tag);
    total++;
    assert ({vendcoke, vendpepsi, vendsoft_drink} === 3'b000) else begin
      bad++;
      $error("FAIL %s vend: observed %b expected 000", tag, {vendcoke, vendpepsi, vendsoft_drink});
    end
`ifdef DRINK_CHANGE_EN
    total++;
    assert (change === 4'd0) else begin
      bad++;
      $error("FAIL %s change: observed %0d expected 0", tag, change);
    end
`endif
  endtask

  // Directed sequence covering every test-plan scenario in order.
  initial begin
    resetn = 1'b0;
    coin = 2'd0;
    coke = 1'b1;
    pepsi = 1'b0;
    soft_drink = 1'b0;

    // Held in reset for 50 ns with coke requested.
    #51;
    checkVendLow("reset");
    checkCredit(4'd0, "reset");
    @(negedge clock);
    resetn = 1'b1;

    // No coins, coke held: nothing vends.
    for (int i = 0; i < 3; i++) applyStimulus(2'd0, 3'b100, 3'b000, 4'd0, "idle_coke");
    checkCredit(4'd0, "idle_coke");

    // Dime, dime, nickel, then coke.
    applyStimulus(2'd2, 3'b000, 3'b000, 4'd0, "ddn_d1");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "ddn_gap");
    applyStimulus(2'd2, 3'b000, 3'b000, 4'd0, "ddn_d2");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "ddn_gap");
    applyStimulus(2'd1, 3'b000, 3'b000, 4'd0, "ddn_n");
    checkCredit(4'd5, "ddn_total");
    applyStimulus(2'd0, 3'b100, 3'b100, 4'd0, "ddn_vend");
    checkCredit(4'd0, "ddn_cleared");
    applyStimulus(2'd0, 3'b100, 3'b000, 4'd0, "ddn_fall");
    applyStimulus(2'd0, 3'b100, 3'b000, 4'd0, "ddn_noagain");

    // Soft drink held before credit is sufficient: dime + three nickels.
    applyStimulus(2'd2, 3'b001, 3'b000, 4'd0, "soft_d");
    applyStimulus(2'd0, 3'b001, 3'b000, 4'd0, "soft_gap");
    applyStimulus(2'd1, 3'b001, 3'b000, 4'd0, "soft_n1");
    applyStimulus(2'd0, 3'b001, 3'b000, 4'd0, "soft_gap");
    applyStimulus(2'd1, 3'b001, 3'b000, 4'd0, "soft_n2");
    applyStimulus(2'd0, 3'b001, 3'b000, 4'd0, "soft_gap");
    applyStimulus(2'd1, 3'b001, 3'b000, 4'd0, "soft_n3");
    applyStimulus(2'd0, 3'b001, 3'b001, 4'd0, "soft_vend");
    applyStimulus(2'd0, 3'b001, 3'b000, 4'd0, "soft_fall");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "soft_rel");

    // Quarter held for three cycles counts once, then pepsi.
    for (int i = 0; i < 3; i++) applyStimulus(2'd3, 3'b000, 3'b000, 4'd0, "q_held");
    checkCredit(4'd5, "q_once");
    applyStimulus(2'd0, 3'b010, 3'b010, 4'd0, "q_pepsi");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "q_fall");

    // Three dimes then coke: one nickel of change.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'd2, 3'b000, 3'b000, 4'd0, "dimes");
      applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "dimes_gap");
    end
    checkCredit(4'd6, "dimes_total");
    applyStimulus(2'd0, 3'b100, 3'b100, 4'd1, "dimes_vend");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "dimes_fall");

    // All selections high: coke wins.
    applyStimulus(2'd3, 3'b000, 3'b000, 4'd0, "prio_q");
    applyStimulus(2'd0, 3'b111, 3'b100, 4'd0, "prio_vend");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "prio_fall");

    // Six quarters saturate credit at 10.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'd3, 3'b000, 3'b000, 4'd0, "sat_q");
      applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "sat_gap");
    end
    checkCredit(4'd10, "sat_credit");
    applyStimulus(2'd0, 3'b100, 3'b100, 4'd5, "sat_vend");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "sat_fall");

    // Coin accepted on the vend edge carries over as the new credit.
    applyStimulus(2'd3, 3'b000, 3'b000, 4'd0, "same_q");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "same_gap");
    applyStimulus(2'd1, 3'b100, 3'b100, 4'd0, "same_vend");
    checkCredit(4'd1, "same_carry");
    applyStimulus(2'd0, 3'b100, 3'b000, 4'd0, "same_fall");
    applyStimulus(2'd0, 3'b100, 3'b000, 4'd0, "same_short");
    checkCredit(4'd1, "same_keep");

    // Dime switching straight to nickel is a single coin.
    applyStimulus(2'd2, 3'b000, 3'b000, 4'd0, "nz_d");
    applyStimulus(2'd1, 3'b000, 3'b000, 4'd0, "nz_n");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "nz_gap");
    checkCredit(4'd3, "nz_credit");

    // Reset with credit 3 clears it immediately.
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checkCredit(4'd0, "midreset");
    checkVendLow("midreset");
    @(negedge clock);
    resetn = 1'b1;
    prevVend = 3'b000;

    // Single quarter plus pepsi after reset.
    applyStimulus(2'd3, 3'b010, 3'b000, 4'd0, "post_q");
    applyStimulus(2'd0, 3'b010, 3'b010, 4'd0, "post_vend");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "post_fall");

    // Reset during a vend pulse drops the output asynchronously.
    applyStimulus(2'd2, 3'b000, 3'b000, 4'd0, "async_d");
    applyStimulus(2'd0, 3'b000, 3'b000, 4'd0, "async_gap");
    applyStimulus(2'd3, 3'b000, 3'b000, 4'd0, "async_q");
    applyStimulus(2'd0, 3'b100, 3'b100, 4'd2, "async_vend");
    resetn = 1'b0;
    #1;
    checkVendLow("async_drop");
    checkCredit(4'd0, "async_drop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
